// File: rtl/palette_sprite_renderer_if.sv
// ============================================================================
// Module   : palette_sprite_renderer_if
// Brief    : Video timing, control, ROM and palette signals of the sprite layer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface palette_sprite_renderer_if #(
    parameter int PIX_BITS = 4,
    parameter int ADDR_W   = 19
);
    logic [9:0]          DrawX;
    logic [9:0]          DrawY;
    logic                blank;
    logic                show;
    logic [9:0]          pos_x;
    logic [9:0]          pos_y;
    logic                pos_we;
    logic                fade_start;
    logic                fade_dir;
    logic [ADDR_W-1:0]   rom_address;
    logic [PIX_BITS-1:0] rom_q;
    logic [PIX_BITS-1:0] pal_index;
    logic [3:0]          palette_red;
    logic [3:0]          palette_green;
    logic [3:0]          palette_blue;
    logic [3:0]          red;
    logic [3:0]          green;
    logic [3:0]          blue;
    logic                opaque;
    logic                fade_busy;

    // System side: VGA timing, control strobes, ROM data and palette lookup.
    modport master (
        output DrawX, DrawY, blank, show, pos_x, pos_y, pos_we,
               fade_start, fade_dir, rom_q, palette_red, palette_green, palette_blue,
        input  rom_address, pal_index, red, green, blue, opaque, fade_busy
    );

    modport slave (
        input  DrawX, DrawY, blank, show, pos_x, pos_y, pos_we,
               fade_start, fade_dir, rom_q, palette_red, palette_green, palette_blue,
        output rom_address, pal_index, red, green, blue, opaque, fade_busy
    );
endinterface

`default_nettype wire

// File: rtl/palette_sprite_renderer.sv
// ============================================================================
// Module   : palette_sprite_renderer
// Brief    : ROM-backed palettized sprite with scaling, colour key and fade.
// Revision : 1.0
// ============================================================================
`default_nettype none

module palette_sprite_renderer #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int SCALE_SHIFT = 0,
    parameter int PIX_BITS    = 4,
    parameter int ADDR_W      = 19,
    parameter int ROM_LAT     = 1,
    parameter int KEY_EN      = 0,
    parameter int KEY_INDEX   = 0,
    parameter int FADE_FRAMES = 2
) (
    input  logic                       vga_clk,
    input  logic                       reset,
    palette_sprite_renderer_if.slave   bus
);
    localparam logic [11:0]         c_SPAN_X   = 12'(IMG_W << SCALE_SHIFT);
    localparam logic [11:0]         c_SPAN_Y   = 12'(IMG_H << SCALE_SHIFT);
    localparam logic [PIX_BITS-1:0] c_KEY      = PIX_BITS'(KEY_INDEX);
    localparam int                  c_CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FADE_IN  = 2'd1,
        S_FADE_OUT = 2'd2
    } fade_state_t;

    logic                w_fs;
    logic [9:0]          r_ax, r_ay, r_px, r_py;
    logic                r_pend;
    logic [11:0]         w_x12, w_y12, w_ax12, w_ay12, w_dx, w_dy;
    logic                w_inside;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   r_rom_address;
    logic [ROM_LAT:0]    r_blank_p, r_inside_p;
    logic                w_vis;
    logic [3:0]          r_red, r_green, r_blue;
    logic                r_opaque;
    fade_state_t         r_state, w_state_nx;
    logic [4:0]          r_level, w_level_nx;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nx;

    assign w_fs = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);

    // Position double-buffer: new positions only take effect at frame start.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_ax   <= '0;
            r_ay   <= '0;
            r_px   <= '0;
            r_py   <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_fs && r_pend) begin
                r_ax <= r_px;
                r_ay <= r_py;
            end
            if (bus.pos_we) begin
                r_px   <= bus.pos_x;
                r_py   <= bus.pos_y;
                r_pend <= 1'b1;
            end else if (w_fs) begin
                r_pend <= 1'b0;
            end
        end
    end

    // 12-bit compares keep ax + span from wrapping past the screen edge.
    assign w_x12    = {2'b00, bus.DrawX};
    assign w_y12    = {2'b00, bus.DrawY};
    assign w_ax12   = {2'b00, r_ax};
    assign w_ay12   = {2'b00, r_ay};
    assign w_dx     = w_x12 - w_ax12;
    assign w_dy     = w_y12 - w_ay12;
    assign w_inside = bus.show
                   && (w_x12 >= w_ax12) && (w_x12 < w_ax12 + c_SPAN_X)
                   && (w_y12 >= w_ay12) && (w_y12 < w_ay12 + c_SPAN_Y);
    assign w_addr   = ADDR_W'(w_dy >> SCALE_SHIFT) * ADDR_W'(IMG_W)
                    + ADDR_W'(w_dx >> SCALE_SHIFT);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_rom_address <= '0;
            r_blank_p     <= '0;
            r_inside_p    <= '0;
        end else begin
            r_rom_address <= w_inside ? w_addr : '0;
            r_blank_p     <= {r_blank_p[ROM_LAT-1:0], bus.blank};
            r_inside_p    <= {r_inside_p[ROM_LAT-1:0], w_inside};
        end
    end

    assign bus.rom_address = r_rom_address;
    assign bus.pal_index   = bus.rom_q;

    assign w_vis = r_blank_p[ROM_LAT] && r_inside_p[ROM_LAT]
                && !((KEY_EN != 0) && (bus.rom_q == c_KEY));

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_opaque <= 1'b0;
        end else begin
            r_opaque <= w_vis;
            r_red    <= w_vis ? 4'((9'(bus.palette_red)   * 9'(r_level)) >> 4) : 4'd0;
            r_green  <= w_vis ? 4'((9'(bus.palette_green) * 9'(r_level)) >> 4) : 4'd0;
            r_blue   <= w_vis ? 4'((9'(bus.palette_blue)  * 9'(r_level)) >> 4) : 4'd0;
        end
    end

    assign bus.red    = r_red;
    assign bus.green  = r_green;
    assign bus.blue   = r_blue;
    assign bus.opaque = r_opaque;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_level <= 5'd16;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_level <= w_level_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // A step that lands on (or starts at) the target level ends the fade.
    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.fade_start) begin
                    w_state_nx = bus.fade_dir ? S_FADE_IN : S_FADE_OUT;
                    w_cnt_nx   = '0;
                end
            end
            S_FADE_IN: begin
                if (w_fs) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nx = '0;
                        if (r_level >= 5'd16) begin
                            w_state_nx = S_IDLE;
                        end else begin
                            w_level_nx = r_level + 5'd1;
                            if (r_level == 5'd15) w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            S_FADE_OUT: begin
                if (w_fs) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nx = '0;
                        if (r_level == 5'd0) begin
                            w_state_nx = S_IDLE;
                        end else begin
                            w_level_nx = r_level - 5'd1;
                            if (r_level == 5'd1) w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign bus.fade_busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_palette_sprite_renderer.sv
// ============================================================================
// Module   : tb_palette_sprite_renderer
// Brief    : Randomized scoreboard bench for palette_sprite_renderer.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_palette_sprite_renderer;
    localparam int IMG_W       = 32;
    localparam int IMG_H       = 32;
    localparam int SCALE_SHIFT = 1;
    localparam int PIX_BITS    = 4;
    localparam int ADDR_W      = 12;
    localparam int ROM_LAT     = 2;
    localparam int KEY_EN      = 1;
    localparam int KEY_INDEX   = 0;
    localparam int FADE_FRAMES = 2;
    localparam int LAT         = ROM_LAT + 2;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    palette_sprite_renderer_if #(.PIX_BITS(PIX_BITS), .ADDR_W(ADDR_W)) bus();

    palette_sprite_renderer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SCALE_SHIFT), .PIX_BITS(PIX_BITS),
        .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .KEY_EN(KEY_EN), .KEY_INDEX(KEY_INDEX),
        .FADE_FRAMES(FADE_FRAMES)
    ) dut (
        .vga_clk(vga_clk),
        .reset(rst),
        .bus(bus)
    );

    // Image content and palette are fixed functions of address / index.
    function automatic int rom_fn(input int a);
        return ((a * 5) ^ (a >> 3)) & 15;
    endfunction
    function automatic int pal_r(input int i); return i;          endfunction
    function automatic int pal_g(input int i); return 15 - i;     endfunction
    function automatic int pal_b(input int i); return i ^ 9;      endfunction

    logic [PIX_BITS-1:0] rom_pipe [ROM_LAT];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= PIX_BITS'(rom_fn(int'(bus.rom_address)));
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_q         = rom_pipe[ROM_LAT-1];
    assign bus.palette_red   = 4'(pal_r(int'(bus.pal_index)));
    assign bus.palette_green = 4'(pal_g(int'(bus.pal_index)));
    assign bus.palette_blue  = 4'(pal_b(int'(bus.pal_index)));

    typedef struct { int due; int addr; }         aexp_t;
    typedef struct { int due; bit vis; int idx; } pexp_t;
    aexp_t aq[$];
    pexp_t pq[$];
    int    level_hist [int];
    bit    busy_hist  [int];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    int m_ax, m_ay, m_px, m_py, m_level, m_frames;
    bit m_pend, m_busy, m_dir;

    task automatic model_reset();
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_pend = 0;
        m_level = 16; m_busy = 0; m_dir = 0; m_frames = 0;
    endtask

    task automatic drive_cycle(input int x, input int y, input bit bl, input bit sh,
                               input bit we, input int wx, input int wy,
                               input bit fst, input bit fdir, input bit push);
        int  c, addr, idx, tgt;
        bit  fs, in;
        @(posedge vga_clk); #1;
        bus.DrawX = 10'(x);  bus.DrawY = 10'(y);
        bus.blank = bl;      bus.show  = sh;
        bus.pos_we = we;     bus.pos_x = 10'(wx);  bus.pos_y = 10'(wy);
        bus.fade_start = fst; bus.fade_dir = fdir;
        c = cyc;
        level_hist[c] = m_level;
        busy_hist[c]  = m_busy;
        fs   = (x == 0) && (y == 0);
        in   = sh && x >= m_ax && x < m_ax + (IMG_W << SCALE_SHIFT)
                  && y >= m_ay && y < m_ay + (IMG_H << SCALE_SHIFT);
        addr = in ? ((y - m_ay) >> SCALE_SHIFT) * IMG_W + ((x - m_ax) >> SCALE_SHIFT) : 0;
        idx  = rom_fn(addr);
        if (push) begin
            aq.push_back('{c + 1, addr});
            pq.push_back('{c + LAT, bl && in && !(KEY_EN != 0 && idx == KEY_INDEX), idx});
        end
        if (fs && m_pend) begin m_ax = m_px; m_ay = m_py; m_pend = 0; end
        if (we) begin m_px = wx; m_py = wy; m_pend = 1; end
        if (m_busy) begin
            if (fs) begin
                m_frames++;
                if (m_frames % FADE_FRAMES == 0) begin
                    tgt = m_dir ? 16 : 0;
                    if (m_level != tgt) m_level += m_dir ? 1 : -1;
                    if (m_level == tgt) m_busy = 0;
                end
            end
        end else if (fst) begin
            m_busy = 1; m_dir = fdir; m_frames = 0;
        end
    endtask

    task automatic rand_cycle();
        int x, y;
        bit we, fst;
        if ($urandom_range(0, 23) == 0) begin
            x = 0; y = 0;
        end else if ($urandom_range(0, 1) == 0) begin
            x = m_ax + $urandom_range(0, 72) - 4;
            y = m_ay + $urandom_range(0, 72) - 4;
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            if (x > 1023) x = 1023;
            if (y > 1023) y = 1023;
        end else begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
        end
        we  = ($urandom_range(0, 59) == 0);
        fst = ($urandom_range(0, 39) == 0);
        drive_cycle(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0,
                    we, $urandom_range(0, 300), $urandom_range(0, 200),
                    fst, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    // Monitor: pops whichever expectation falls due this cycle.
    always @(negedge vga_clk) begin
        if (!rst) begin
            if (aq.size() > 0 && aq[0].due == cyc) begin
                aexp_t a;
                a = aq.pop_front();
                check("rom_address", int'(bus.rom_address), a.addr);
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pexp_t p;
                int    lv, er, eg, eb;
                p  = pq.pop_front();
                lv = level_hist.exists(p.due - 1) ? level_hist[p.due - 1] : -1;
                er = p.vis ? ((pal_r(p.idx) * lv) >> 4) & 15 : 0;
                eg = p.vis ? ((pal_g(p.idx) * lv) >> 4) & 15 : 0;
                eb = p.vis ? ((pal_b(p.idx) * lv) >> 4) & 15 : 0;
                check("pixel{opaque,r,g,b}",
                      int'({bus.opaque, bus.red, bus.green, bus.blue}),
                      (int'(p.vis) << 12) | (er << 8) | (eg << 4) | eb);
            end
            if (busy_hist.exists(cyc))
                check("fade_busy", int'(bus.fade_busy), int'(busy_hist[cyc]));
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_red"},     int'(bus.red),         0);
        check({tag, "_green"},   int'(bus.green),       0);
        check({tag, "_blue"},    int'(bus.blue),        0);
        check({tag, "_opaque"},  int'(bus.opaque),      0);
        check({tag, "_busy"},    int'(bus.fade_busy),   0);
        check({tag, "_address"}, int'(bus.rom_address), 0);
    endtask

    initial begin
        bus.DrawX = '0; bus.DrawY = '0; bus.blank = 0; bus.show = 0;
        bus.pos_x = '0; bus.pos_y = '0; bus.pos_we = 0;
        bus.fade_start = 0; bus.fade_dir = 0;
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Position (100,50), scale 2: edge and address-step points.
        drive_cycle(300, 300, 1, 1, 1, 100, 50, 0, 0, 1);
        drive_cycle(0,   0,   1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(99,  50,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(100, 50,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(101, 50,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(102, 50,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(100, 52,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(163, 50,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(164, 50,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(120, 60,  0, 1, 0, 0,   0,  0, 0, 1);

        // Mid-frame move to (200,10) only appears after the next frame start.
        drive_cycle(130, 70,  1, 1, 1, 200, 10, 0, 0, 1);
        drive_cycle(200, 10,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(110, 55,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(0,   0,   1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(199, 10,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(200, 10,  1, 1, 0, 0,   0,  0, 0, 1);
        drive_cycle(110, 55,  1, 1, 0, 0,   0,  0, 0, 1);

        // Fade out from 16, with a second start while busy that must be ignored.
        drive_cycle(500, 500, 1, 1, 0, 0, 0, 1, 0, 1);
        drive_cycle(500, 500, 1, 1, 0, 0, 0, 1, 1, 1);
        for (int f = 0; f < 34; f++) begin
            drive_cycle(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
            for (int k = 0; k < 6; k++)
                drive_cycle(200 + $urandom_range(0, 63), 10 + $urandom_range(0, 63),
                            1, 1, 0, 0, 0, 0, 0, 1);
        end

        for (int n = 0; n < 2500; n++) rand_cycle();

        // Asynchronous reset in the middle of a cycle.
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        aq.delete(); pq.delete();
        level_hist.delete(); busy_hist.delete();
        model_reset();
        repeat (2) @(posedge vga_clk);
        #1 rst = 1'b0;

        drive_cycle(300, 300, 1, 1, 1, 40, 30, 0, 0, 1);
        drive_cycle(0,   0,   1, 1, 0, 0,  0,  0, 0, 1);
        for (int n = 0; n < 1500; n++) rand_cycle();

        for (int n = 0; n < LAT + 2; n++)
            drive_cycle(900, 900, 0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_queues_empty", aq.size() + pq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/palette_sprite_renderer.md
Name: palette_sprite_renderer

Overview:
- Parametrised successor to the fixed 640x480 palettized background renderer.
- Draws one ROM-backed palettized image of configurable size at a runtime position, with power-of-2 integer scaling, a transparent colour key and a per-frame fade engine.
- Sits between the VGA controller (DrawX/DrawY/blank) and the layer mixer.
- ROM and palette are external instances; `opaque` tells the mixer when this layer owns the pixel.

Parameters:
- IMG_W, 640, image width in source pixels.
- IMG_H, 480, image height in source pixels.
- SCALE_SHIFT, 0, on-screen scale factor = 2^SCALE_SHIFT in both axes (0..3).
- PIX_BITS, 4, palette index width.
- ADDR_W, 19, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- ROM_LAT, 1, ROM read latency in vga_clk cycles (1..3).
- KEY_EN, 0, 1 = palette index KEY_INDEX is transparent.
- KEY_INDEX, 0, transparent index value.
- FADE_FRAMES, 2, frames per brightness step while fading (>=1).

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- show  in  1  layer enable, sampled with DrawX.
- pos_x  in  10  requested image left edge.
- pos_y  in  10  requested image top edge.
- pos_we  in  1  1-cycle strobe to capture pos_x/pos_y.
- fade_start  in  1  1-cycle strobe that starts a fade.
- fade_dir  in  1  1 = fade in (to full), 0 = fade out (to black).
- rom_address  out  ADDR_W  registered ROM address.
- rom_q  in  PIX_BITS  ROM data, valid ROM_LAT cycles after rom_address.
- pal_index  out  PIX_BITS  equals rom_q, driven to the external combinational palette.
- palette_red, palette_green, palette_blue  in  4 each  palette result for pal_index.
- red, green, blue  out  4 each  registered pixel colour.
- opaque  out  1  registered; 1 = this layer's pixel is valid.
- fade_busy  out  1  1 while the fade FSM is not IDLE.

Behaviour:
- Reset values: all outputs 0, except fade_busy=0. Active position (0,0). Pending position empty. Brightness level = 16. FSM = IDLE. Frame counter = 0. All pipeline valid bits 0.
- Frame-start event (fs): DrawX==0 && DrawY==0 at the input, for one cycle.
- Position double-buffer:
  - pos_we loads the pending regs and sets the pending flag; a later pos_we overwrites them.
  - On fs with pending set, active <= pending and the flag clears.
  - pos_we coincident with fs: the new value is captured as pending and applied at the next fs. The image never tears mid-frame.
- Stage 1 (registered):
  - inside = show && DrawX >= ax && DrawX < ax + (IMG_W<<SCALE_SHIFT) && DrawY >= ay && DrawY < ay + (IMG_H<<SCALE_SHIFT).
  - Compares use 12-bit unsigned arithmetic, so no wrap at the right or bottom edge. An image partly off screen is clipped.
  - rom_address = ((DrawY-ay)>>SCALE_SHIFT)*IMG_W + ((DrawX-ax)>>SCALE_SHIFT) when inside, else 0.
  - blank and inside are also registered.
- Delay: blank and inside are delayed ROM_LAT further cycles to align with rom_q.
- Output stage (registered):
  - vis = blank_d && inside_d && !(KEY_EN && rom_q==KEY_INDEX).
  - opaque <= vis.
  - Each colour channel c <= vis ? (palette_c * level) >> 4 : 0. The product is 9 bits and the result is truncated to 4 bits; level 16 gives identity.
- Latency: DrawX/DrawY/blank to red/green/blue/opaque = ROM_LAT+2 cycles, constant for all positions and modes.
- Fade FSM states: IDLE, FADE_IN, FADE_OUT.
  - fade_start in IDLE: go to FADE_IN if fade_dir=1, else FADE_OUT; frame counter <= 0. Takes effect the next cycle.
  - fade_start while busy: ignored.
  - In FADE_*, each fs increments the frame counter. When the counter reaches FADE_FRAMES-1, it resets to 0 and the level steps by ±1.
  - FADE_IN returns to IDLE when level reaches 16; FADE_OUT returns to IDLE when level reaches 0.
  - If the level is already at the target, the FSM returns to IDLE at the first step with no change.
  - Level saturates to 0..16. Level persists in IDLE.
- Mid-frame reset: all state returns to reset values immediately (asynchronous). The first valid pixel appears ROM_LAT+2 cycles after deassertion.

Test Plan:
- Defaults, show=1, blank=1, sweep line 0: rom_address tracks DrawX (0..639) one cycle later. red/green/blue equal the palette output 3 cycles after the DrawX sample. opaque=1.
- IMG_W=32, IMG_H=32, SCALE_SHIFT=1, pos (100,50): DrawX=99 gives opaque=0. DrawX=100/101 at DrawY=50 both give address 0; DrawX=102 gives address 1. DrawY=52 gives address 32. DrawX=164 gives opaque=0.
- pos_we with (200,10) mid-frame: the current frame still uses the old position. After the next fs, the image's left edge is at DrawX=200.
- KEY_EN=1, KEY_INDEX=0: pixel with rom_q=0 gives opaque=0 and rgb=0. rom_q=3 gives opaque=1.
- FADE_FRAMES=2, fade_start with fade_dir=0 from level 16: level reaches 0 after 32 fs. palette_red=F at level 8 gives red=7. fade_busy drops when level hits 0. A second fade_start while busy is ignored.
- Assert reset mid-line: all outputs are 0 immediately and level=16. blank=0 at any level forces rgb=0 and opaque=0.
